// File: rtl/pe_pkg.sv
// Shared PE definitions: adder flag layout, skid buffer state encoding, default widths.
package pe_pkg;

  localparam int DATA_W = 16;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;

  typedef struct packed {
    logic v;
    logic n;
    logic z;
    logic c;
  } flags_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/pe_result_skid_if.sv
// Result bus between the PE adder (master) and the result skid stage (slave).
interface pe_result_skid_if
  import pe_pkg::*;
#(
  parameter int WIDTH = 16
);

  // Handshake: a beat transfers on a rising edge where valid & ready are both 1.
  // Ready/valid driven by the stage depend only on its registered state and clk_en.
  logic [WIDTH-1:0] in_data;
  flags_t           in_flags;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  flags_t           out_flags;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output in_data, in_flags, in_valid, out_ready,
    input  in_ready, out_data, out_flags, out_valid
  );

  modport slave (
    input  in_data, in_flags, in_valid, out_ready,
    output in_ready, out_data, out_flags, out_valid
  );

endinterface

// File: rtl/pe_skid_buf.sv
// Generic 2-entry valid/ready skid buffer; main register m feeds the output, s catches the overflow.
module pe_skid_buf
  import pe_pkg::*;
#(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] in_payload,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_payload,
  output logic         out_valid,
  input  logic         out_ready,
  output skid_state_e  state
);

  skid_state_e state_nxt;
  logic [W-1:0] m_q, m_nxt;
  logic [W-1:0] s_q, s_nxt;
  logic acc;
  logic dlv;

  // rst_n keeps in_ready low while reset is held even though state is already EMPTY
  assign in_ready    = en & rst_n & (state != FULL);
  assign out_valid   = en & (state != EMPTY);
  assign out_payload = m_q;
  assign acc         = in_valid & in_ready;
  assign dlv         = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      m_q   <= '0;
      s_q   <= '0;
    end else begin
      state <= state_nxt;
      m_q   <= m_nxt;
      s_q   <= s_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    m_nxt     = m_q;
    s_nxt     = s_q;
    unique case (state)
      EMPTY: begin
        if (acc) begin
          m_nxt     = in_payload;
          state_nxt = ONE;
        end
      end
      ONE: begin
        if (acc && dlv) begin
          m_nxt = in_payload;
        end else if (acc) begin
          s_nxt     = in_payload;
          state_nxt = FULL;
        end else if (dlv) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (dlv) begin
          m_nxt     = s_q;
          state_nxt = ONE;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

endmodule

// File: rtl/pe_result_skid.sv
// PE adder output stage: skid-buffers {flags, sum} and tracks sticky C/V plus a delivered-result count.
module pe_result_skid
  import pe_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic              CLK,
  input  logic              ASYNCRESET,
  input  logic              clk_en,
  input  logic              clr_sticky,
  pe_result_skid_if.slave   bus,
  output logic              sticky_c,
  output logic              sticky_v,
  output logic [CNT_W-1:0]  out_count,
  output skid_state_e       dbg_state
);

  logic [WIDTH+3:0] buf_out;
  logic acc;
  logic dlv;

  pe_skid_buf #(.W(WIDTH + 4)) u_buf (
    .clk         (CLK),
    .rst_n       (ASYNCRESET),
    .en          (clk_en),
    .in_payload  ({bus.in_flags, bus.in_data}),
    .in_valid    (bus.in_valid),
    .in_ready    (bus.in_ready),
    .out_payload (buf_out),
    .out_valid   (bus.out_valid),
    .out_ready   (bus.out_ready),
    .state       (dbg_state)
  );

  assign {bus.out_flags, bus.out_data} = buf_out;
  assign acc = bus.in_valid & bus.in_ready;
  assign dlv = bus.out_valid & bus.out_ready;

  // A flag set by this cycle's accepted result wins over a simultaneous clear
  always_ff @(posedge CLK or negedge ASYNCRESET) begin
    if (!ASYNCRESET) begin
      sticky_c <= 1'b0;
      sticky_v <= 1'b0;
    end else if (clk_en) begin
      sticky_c <= (sticky_c & ~clr_sticky) | (acc & bus.in_flags[FLAG_C]);
      sticky_v <= (sticky_v & ~clr_sticky) | (acc & bus.in_flags[FLAG_V]);
    end
  end

  always_ff @(posedge CLK or negedge ASYNCRESET) begin
    if (!ASYNCRESET) begin
      out_count <= '0;
    end else if (clk_en) begin
      if (clr_sticky) begin
        out_count <= dlv ? CNT_W'(1) : '0;
      end else if (dlv && (out_count != {CNT_W{1'b1}})) begin
        out_count <= out_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pe_result_skid.sv
// Scoreboarded bench for pe_result_skid (counter narrowed to 4 bits to reach saturation quickly).
module tb_pe_result_skid;
  import pe_pkg::*;

  localparam int WIDTH = 16;
  localparam int CNT_W = 4;

  logic CLK;
  logic ASYNCRESET;
  logic clk_en;
  logic clr_sticky;
  logic sticky_c;
  logic sticky_v;
  logic [CNT_W-1:0] out_count;
  skid_state_e dbg_state;

  pe_result_skid_if #(.WIDTH(WIDTH)) bus ();

  pe_result_skid #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .CLK        (CLK),
    .ASYNCRESET (ASYNCRESET),
    .clk_en     (clk_en),
    .clr_sticky (clr_sticky),
    .bus        (bus.slave),
    .sticky_c   (sticky_c),
    .sticky_v   (sticky_v),
    .out_count  (out_count),
    .dbg_state  (dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [WIDTH+3:0] exp_q[$];

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard: every delivered beat must match the oldest accepted beat
  always @(negedge CLK) begin
    if (bus.out_valid && bus.out_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_extra: got %h, nothing expected", {bus.out_flags, bus.out_data});
      end else begin
        logic [WIDTH+3:0] e;
        e = exp_q.pop_front();
        if ({bus.out_flags, bus.out_data} !== e) begin
          n_fail++;
          $display("FAIL scoreboard_data: got %h expected %h", {bus.out_flags, bus.out_data}, e);
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [WIDTH-1:0] d, input logic [3:0] f, input int max_wait, output bit ok);
    bus.in_data  = d;
    bus.in_flags = f;
    bus.in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < max_wait && !ok; i++) begin
      @(negedge CLK);
      if (bus.in_ready) begin
        exp_q.push_back({f, d});
        ok = 1'b1;
      end
      tick();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic send_must(input logic [WIDTH-1:0] d, input logic [3:0] f);
    bit ok;
    send(d, f, 20, ok);
    n_checks++;
    if (ok !== 1'b1) begin
      n_fail++;
      $display("FAIL send_accept: data %h not accepted within 20 cycles", d);
    end
  endtask

  task automatic drain(input string tag);
    int i;
    for (i = 0; i < 200; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d entries still pending", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic pulse_clr();
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
  endtask

  // scenarios
  task automatic test_reset();
    ASYNCRESET = 1'b0;
    clk_en = 1'b1;
    clr_sticky = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_flags = '0;
    bus.out_ready = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({bus.in_ready, bus.out_valid, sticky_c, sticky_v} !== 4'b0000 || out_count !== '0
        || bus.out_data !== '0 || bus.out_flags !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_values: rdy=%b vld=%b sc=%b sv=%b cnt=%0d data=%h flags=%b, required all 0",
               bus.in_ready, bus.out_valid, sticky_c, sticky_v, out_count, bus.out_data, bus.out_flags);
    end
    ASYNCRESET = 1'b1;
    @(negedge CLK);
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b, required 1/0", bus.in_ready, bus.out_valid);
    end
    tick();
  endtask

  task automatic test_stream();
    bus.out_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      send_must(WIDTH'(k), 4'b0000);
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== WIDTH'(k)) begin
        n_fail++;
        $display("FAIL stream_latency: valid=%b data=%h, required 1/%h", bus.out_valid, bus.out_data, k);
      end
    end
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b0 || out_count !== 4'd3) begin
      n_fail++;
      $display("FAIL stream_count: valid=%b count=%0d, required 0/3", bus.out_valid, out_count);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    bus.out_ready = 1'b0;
    send_must(16'h00AA, 4'b0000);
    send_must(16'h00BB, 4'b0000);
    send(16'h00CC, 4'b0000, 3, ok);
    n_checks++;
    if (ok !== 1'b0 || bus.in_ready !== 1'b0 || dbg_state !== FULL) begin
      n_fail++;
      $display("FAIL bp_full: accepted=%b in_ready=%b state=%0d, required 0/0/FULL", ok, bus.in_ready, dbg_state);
    end
    bus.out_ready = 1'b1;
    send_must(16'h00CC, 4'b0000);
    drain("bp");
    n_checks++;
    if (out_count !== 4'd6 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_count: count=%0d valid=%b, required 6/0", out_count, bus.out_valid);
    end
  endtask

  task automatic test_sticky();
    bus.out_ready = 1'b0;
    send_must(16'h0042, 4'b0000);
    clr_sticky = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    clr_sticky = 1'b0;
    n_checks++;
    if (out_count !== 4'd1) begin
      n_fail++;
      $display("FAIL clr_with_dlv: count=%0d, required 1", out_count);
    end
    send_must(16'hFFFF, 4'b0001);
    send_must(16'h8000, 4'b1100);
    drain("sticky");
    n_checks++;
    if (sticky_c !== 1'b1 || sticky_v !== 1'b1) begin
      n_fail++;
      $display("FAIL sticky_set: c=%b v=%b, required 1/1", sticky_c, sticky_v);
    end
    pulse_clr();
    n_checks++;
    if (sticky_c !== 1'b0 || sticky_v !== 1'b0 || out_count !== '0) begin
      n_fail++;
      $display("FAIL sticky_clr: c=%b v=%b count=%0d, required 0/0/0", sticky_c, sticky_v, out_count);
    end
    clr_sticky = 1'b1;
    send_must(16'h1234, 4'b1000);
    clr_sticky = 1'b0;
    n_checks++;
    if (sticky_c !== 1'b0 || sticky_v !== 1'b1) begin
      n_fail++;
      $display("FAIL sticky_clr_vs_set: c=%b v=%b, required 0/1", sticky_c, sticky_v);
    end
    drain("sticky2");
    n_checks++;
    if (out_count !== 4'd1) begin
      n_fail++;
      $display("FAIL sticky_count: count=%0d, required 1", out_count);
    end
  endtask

  task automatic test_freeze();
    bus.out_ready = 1'b0;
    send_must(16'h1111, 4'b0000);
    send_must(16'h2222, 4'b0000);
    clk_en = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      n_checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL freeze_handshake: valid=%b ready=%b, required 0/0", bus.out_valid, bus.in_ready);
      end
    end
    tick();
    n_checks++;
    if (out_count !== 4'd1 || dbg_state !== FULL || bus.out_data !== 16'h1111) begin
      n_fail++;
      $display("FAIL freeze_hold: count=%0d state=%0d data=%h, required 1/FULL/1111", out_count, dbg_state, bus.out_data);
    end
    clk_en = 1'b1;
    drain("freeze");
    n_checks++;
    if (out_count !== 4'd3) begin
      n_fail++;
      $display("FAIL freeze_resume_count: count=%0d, required 3", out_count);
    end
  endtask

  task automatic test_saturation();
    bus.out_ready = 1'b1;
    pulse_clr();
    for (int i = 0; i < 12; i++)
      send_must(WIDTH'($urandom_range(0, 16'hFFFF)), 4'($urandom_range(0, 15)));
    drain("sat12");
    n_checks++;
    if (out_count !== 4'd12) begin
      n_fail++;
      $display("FAIL count_12: count=%0d, required 12", out_count);
    end
    for (int i = 0; i < 8; i++)
      send_must(WIDTH'($urandom_range(0, 16'hFFFF)), 4'($urandom_range(0, 15)));
    drain("sat20");
    n_checks++;
    if (out_count !== 4'd15) begin
      n_fail++;
      $display("FAIL count_saturate: count=%0d, required 15", out_count);
    end
  endtask

  task automatic test_async_reset();
    bus.out_ready = 1'b0;
    send_must(16'h0101, 4'b1001);
    send_must(16'h0202, 4'b0000);
    #2;
    ASYNCRESET = 1'b0;
    #1;
    exp_q.delete();
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || sticky_c !== 1'b0 || sticky_v !== 1'b0
        || out_count !== '0 || bus.out_data !== '0 || dbg_state !== EMPTY) begin
      n_fail++;
      $display("FAIL async_reset: vld=%b rdy=%b sc=%b sv=%b cnt=%0d data=%h state=%0d, required all 0/EMPTY",
               bus.out_valid, bus.in_ready, sticky_c, sticky_v, out_count, bus.out_data, dbg_state);
    end
    tick();
    ASYNCRESET = 1'b1;
    bus.out_ready = 1'b1;
    send_must(16'h0055, 4'b0000);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h0055) begin
      n_fail++;
      $display("FAIL post_reset_first: valid=%b data=%h, required 1/0055", bus.out_valid, bus.out_data);
    end
    drain("post_reset");
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_sticky();
    test_freeze();
    test_saturation();
    test_async_reset();
    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pe_result_skid.md
Name: pe_result_skid

Overview:
- Output stage directly downstream of the PE adder; consumes the 16-bit sum and its carry/zero/negative/overflow flags.
- Buffers each result in a 2-entry skid buffer with valid/ready handshakes on both sides, so a stalled consumer never drops adder results.
- Keeps sticky carry/overflow flags and a saturating count of delivered results for debug and status readback.

Parameters:
- WIDTH, 16, data width of the adder result.
- CNT_W, 16, width of the delivered-result counter.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- ASYNCRESET  input  1  asynchronous reset, active-low; clears all state immediately on assertion.
- clk_en  input  1  global stage enable; 0 freezes all state.
- in_data  input  WIDTH  adder sum.
- in_flags  input  4  {V,N,Z,C}; C=bit0, Z=bit1, N=bit2, V=bit3.
- in_valid  input  1  upstream result valid.
- in_ready  output  1  stage can accept a result.
- out_data  output  WIDTH  buffered sum, oldest first.
- out_flags  output  4  flags paired with out_data.
- out_valid  output  1  out_data/out_flags valid.
- out_ready  input  1  consumer accepts.
- clr_sticky  input  1  clears sticky flags and the counter.
- sticky_c  output  1  set once any accepted result had C=1.
- sticky_v  output  1  set once any accepted result had V=1.
- out_count  output  CNT_W  delivered results, saturating.

Behaviour:
- Transfer rules:
  - Input transfer (acc) = in_valid & in_ready.
  - Output transfer (dlv) = out_valid & out_ready.
  - in_ready = clk_en & (state != FULL).
  - out_valid = clk_en & (state != EMPTY).
  - Both are combinational from registered state and clk_en only, never from in_valid or out_ready.
- Storage: main register M drives out_data/out_flags; skid register S holds the second entry. Data and flags are stored together as {flags, data}.
- FSM states: EMPTY, ONE, FULL. Reset state is EMPTY.
  - EMPTY: acc -> load M, go to ONE.
  - ONE, acc only -> load S, go to FULL.
  - ONE, dlv only -> go to EMPTY.
  - ONE, acc & dlv -> load M with the new input, stay in ONE.
  - FULL: in_ready=0. dlv -> M<=S, go to ONE.
- Latency: a result accepted in cycle t appears on out_* with out_valid=1 in cycle t+1 when the buffer was empty or drained. Throughput is one result per cycle while out_ready=1.
- Ordering: strictly FIFO; no result is ever lost or duplicated.
- clk_en=0: no transfers occur, M, S, FSM state, sticky flags and counter all hold, and in_ready=out_valid=0. Resumes exactly where it stopped when clk_en returns to 1.
- Sticky flags:
  - On acc, sticky_c |= in_flags[0] and sticky_v |= in_flags[3].
  - clr_sticky clears both flags and out_count when clk_en=1.
  - If clr_sticky coincides with an acc whose flag is 1, the set wins: the flag ends at 1.
  - clr_sticky is ignored when clk_en=0.
- Counter:
  - out_count increments by 1 on each dlv and saturates at 2^CNT_W-1; no wrap.
  - If clr_sticky coincides with a dlv, the result is 1.
- Reset values: FSM=EMPTY, M=S=0, out_data=0, out_flags=0, out_valid=0, in_ready=0 while reset is asserted, sticky_c=sticky_v=0, out_count=0.
- Reset mid-operation discards all buffered entries. In the first cycle after deassertion, in_ready=clk_en.
- Arithmetic: no arithmetic on data; the counter is an unsigned CNT_W-bit increment with saturation compare.

Decomposition:
- Shared package pe_pkg:
  - flags_t, a 4-bit packed struct {v,n,z,c}.
  - Index constants FLAG_C=0, FLAG_Z=1, FLAG_N=2, FLAG_V=3.
  - Skid state enum {EMPTY, ONE, FULL}.
  - Default DATA_W=16.
- The adder flag-producing block and downstream PE stages import the same package.
- One natural sub-module, pe_skid_buf, a generic 2-entry valid/ready skid buffer parameterised on payload width. pe_result_skid instantiates it with payload WIDTH+4 and adds the sticky and counter logic around it.

Test Plan:
- Reset then stream: release ASYNCRESET, clk_en=1, out_ready=1, drive 0x0001,0x0002,0x0003 back to back -> out_data 0x0001,0x0002,0x0003 on consecutive cycles starting 1 cycle after the first acc; out_count=3.
- Backpressure: out_ready=0, offer 0x00AA, 0x00BB, 0x00CC -> two accepted, in_ready=0 holding 0x00CC; then out_ready=1 -> outputs 0x00AA, 0x00BB, 0x00CC in order, none lost.
- Sticky flags: accept 0xFFFF with flags 4'b0001 (C), then 0x8000 with flags 4'b1100 (V,N) -> sticky_c=1, sticky_v=1. clr_sticky alone -> both 0 and out_count=0. clr_sticky coinciding with acc of flags 4'b1000 -> sticky_v=1, sticky_c=0.
- clk_en freeze: FULL with 0x1111 and 0x2222, drop clk_en for 5 cycles with out_ready=1 -> out_valid=0, in_ready=0, count unchanged. Restore clk_en -> 0x1111 then 0x2222 delivered.
- Counter saturation: CNT_W=4, deliver 20 results -> out_count stops at 15.
- Async reset mid-stream: assert ASYNCRESET (low) between clock edges while FULL -> out_valid and all flags and counter drop to 0 immediately. After release, accept 0x0055 -> it is the next output.
